// File: rtl/mm_job_arbiter.sv
// Two-requester job arbiter: forwards one matrix job (A block then B block) to the
// accelerator, then routes the accelerator's result stream back to the job owner.
module mm_job_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM_LOG    = 1
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic [DATA_WIDTH-1:0] rq0_tdata,
  input  logic                  rq0_tvalid,
  input  logic                  rq0_tlast,
  output logic                  rq0_tready,
  input  logic [DATA_WIDTH-1:0] rq1_tdata,
  input  logic                  rq1_tvalid,
  input  logic                  rq1_tlast,
  output logic                  rq1_tready,
  output logic [DATA_WIDTH-1:0] acc_tdata,
  output logic                  acc_tvalid,
  output logic                  acc_tlast,
  input  logic                  acc_tready,
  input  logic [DATA_WIDTH-1:0] res_tdata,
  input  logic                  res_tvalid,
  input  logic                  res_tlast,
  output logic                  res_tready,
  output logic [DATA_WIDTH-1:0] rs0_tdata,
  output logic                  rs0_tvalid,
  output logic                  rs0_tlast,
  input  logic                  rs0_tready,
  output logic [DATA_WIDTH-1:0] rs1_tdata,
  output logic                  rs1_tvalid,
  output logic                  rs1_tlast,
  input  logic                  rs1_tready,
  output logic                  sel,
  output logic                  start,
  output logic                  busy,
  output logic                  grant,
  output logic                  err_len
);

  localparam int SIZE    = (2**DIM_LOG)**2;
  localparam int JOB_LEN = 2*SIZE;
  localparam int CW      = 2*DIM_LOG + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(JOB_LEN - 1);
  localparam logic [CW-1:0] SIZE_IDX = CW'(SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_RES} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          last_grant;
  logic          in_valid;
  logic          in_last;
  logic          accept;
  logic          in_load;
  logic          in_wait;
  logic          res_accept;

  assign in_load  = (state == LOAD);
  assign in_wait  = (state == WAIT_RES);
  assign in_valid = grant ? rq1_tvalid : rq0_tvalid;
  assign in_last  = grant ? rq1_tlast  : rq0_tlast;

  assign acc_tdata  = grant ? rq1_tdata : rq0_tdata;
  assign acc_tvalid = in_load && in_valid;
  // Job framing comes from the word count; the requester's tlast only flags length errors.
  assign acc_tlast  = acc_tvalid && (count == LAST_IDX);
  assign accept     = acc_tvalid && acc_tready;
  assign rq0_tready = in_load && !grant && acc_tready;
  assign rq1_tready = in_load &&  grant && acc_tready;

  assign res_tready = in_wait && (grant ? rs1_tready : rs0_tready);
  assign res_accept = res_tvalid && res_tready;
  assign rs0_tdata  = res_tdata;
  assign rs1_tdata  = res_tdata;
  assign rs0_tvalid = in_wait && !grant && res_tvalid;
  assign rs1_tvalid = in_wait &&  grant && res_tvalid;
  assign rs0_tlast  = in_wait && !grant && res_tlast;
  assign rs1_tlast  = in_wait &&  grant && res_tlast;

  assign sel   = (count >= SIZE_IDX);
  assign start = (state == START);
  assign busy  = (state != IDLE);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          if (rq0_tvalid || rq1_tvalid) begin
            // Contention alternates against the previous winner.
            if (rq0_tvalid && rq1_tvalid) begin
              grant      <= ~last_grant;
              last_grant <= ~last_grant;
            end else begin
              grant      <= rq1_tvalid;
              last_grant <= rq1_tvalid;
            end
            count <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            if (count == LAST_IDX) begin
              err_len <= ~in_last;
              count   <= '0;
              state   <= START;
            end else if (in_last) begin
              err_len <= 1'b1;
              count   <= '0;
              state   <= IDLE;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        START: state <= WAIT_RES;
        WAIT_RES: begin
          if (res_accept && res_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Bench for mm_job_arbiter: job-level reference model checked every cycle plus
// directed scenarios with literal expectations.
module tb_mm_job_arbiter;

  localparam int SIZE    = 4;
  localparam int JOB_LEN = 8;
  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_START = 2;
  localparam int P_WAIT  = 3;

  logic        clk;
  logic        rst_n;
  logic [31:0] rq0_tdata, rq1_tdata, acc_tdata, res_tdata, rs0_tdata, rs1_tdata;
  logic        rq0_tvalid, rq0_tlast, rq0_tready;
  logic        rq1_tvalid, rq1_tlast, rq1_tready;
  logic        acc_tvalid, acc_tlast, acc_tready;
  logic        res_tvalid, res_tlast, res_tready;
  logic        rs0_tvalid, rs0_tlast, rs0_tready;
  logic        rs1_tvalid, rs1_tlast, rs1_tready;
  logic        sel, start, busy, grant, err_len;
  logic        acc_toggle;

  int vectors = 0;
  int miscompares = 0;

  int m_phase, m_words;
  bit m_owner, m_prev, m_err;

  logic [31:0] acc_log[$];
  bit          sel_log[$];
  bit          tl_log[$];
  bit          grant_log[$];
  logic [31:0] rs0_log[$];
  int start_cnt, err_cnt, rs1_vcnt;

  mm_job_arbiter #(.DATA_WIDTH(32), .DIM_LOG(1)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .rq0_tdata(rq0_tdata), .rq0_tvalid(rq0_tvalid), .rq0_tlast(rq0_tlast), .rq0_tready(rq0_tready),
    .rq1_tdata(rq1_tdata), .rq1_tvalid(rq1_tvalid), .rq1_tlast(rq1_tlast), .rq1_tready(rq1_tready),
    .acc_tdata(acc_tdata), .acc_tvalid(acc_tvalid), .acc_tlast(acc_tlast), .acc_tready(acc_tready),
    .res_tdata(res_tdata), .res_tvalid(res_tvalid), .res_tlast(res_tlast), .res_tready(res_tready),
    .rs0_tdata(rs0_tdata), .rs0_tvalid(rs0_tvalid), .rs0_tlast(rs0_tlast), .rs0_tready(rs0_tready),
    .rs1_tdata(rs1_tdata), .rs1_tvalid(rs1_tvalid), .rs1_tlast(rs1_tlast), .rs1_tready(rs1_tready),
    .sel(sel), .start(start), .busy(busy), .grant(grant), .err_len(err_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no event within bound, required one at %0t", name, $time);
  endtask

  // Expected outputs follow from the job-level view: phase, owner, words taken so far.
  task automatic compare_outputs();
    bit ld, wt, own_v, exp_acc_v, own_rdy;
    ld        = (m_phase == P_LOAD);
    wt        = (m_phase == P_WAIT);
    own_v     = m_owner ? rq1_tvalid : rq0_tvalid;
    own_rdy   = m_owner ? rs1_tready : rs0_tready;
    exp_acc_v = ld && own_v;
    check1("acc_tvalid", acc_tvalid, exp_acc_v);
    if (exp_acc_v) check32("acc_tdata", acc_tdata, m_owner ? rq1_tdata : rq0_tdata);
    check1("acc_tlast", acc_tlast, exp_acc_v && (m_words == JOB_LEN - 1));
    check1("rq0_tready", rq0_tready, ld && !m_owner && acc_tready);
    check1("rq1_tready", rq1_tready, ld && m_owner && acc_tready);
    if (ld || !rst_n) check1("sel", sel, m_words >= SIZE);
    check1("start", start, m_phase == P_START);
    check1("busy", busy, m_phase != P_IDLE);
    check1("grant", grant, m_owner);
    check1("err_len", err_len, m_err);
    check1("res_tready", res_tready, wt && own_rdy);
    check1("rs0_tvalid", rs0_tvalid, wt && !m_owner && res_tvalid);
    check1("rs0_tlast", rs0_tlast, wt && !m_owner && res_tlast);
    check1("rs1_tvalid", rs1_tvalid, wt && m_owner && res_tvalid);
    check1("rs1_tlast", rs1_tlast, wt && m_owner && res_tlast);
    if (wt && !m_owner && res_tvalid) check32("rs0_tdata", rs0_tdata, res_tdata);
    if (wt && m_owner && res_tvalid) check32("rs1_tdata", rs1_tdata, res_tdata);
  endtask

  task automatic model_step();
    bit own_v, own_last, own_rdy;
    own_v    = m_owner ? rq1_tvalid : rq0_tvalid;
    own_last = m_owner ? rq1_tlast : rq0_tlast;
    own_rdy  = m_owner ? rs1_tready : rs0_tready;
    m_err = 1'b0;
    case (m_phase)
      P_IDLE: if (rq0_tvalid || rq1_tvalid) begin
        m_owner = (rq0_tvalid && rq1_tvalid) ? !m_prev : rq1_tvalid;
        m_prev  = m_owner;
        m_words = 0;
        m_phase = P_LOAD;
      end
      P_LOAD: if (own_v && acc_tready) begin
        m_words++;
        if (m_words == JOB_LEN) begin
          m_err   = !own_last;
          m_words = 0;
          m_phase = P_START;
        end else if (own_last) begin
          m_err   = 1'b1;
          m_words = 0;
          m_phase = P_IDLE;
        end
      end
      P_START: m_phase = P_WAIT;
      default: if (res_tvalid && own_rdy && res_tlast) m_phase = P_IDLE;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = P_IDLE; m_owner = 1'b0; m_prev = 1'b1; m_words = 0; m_err = 1'b0;
      end
      compare_outputs();
      if (acc_tvalid && acc_tready) begin
        acc_log.push_back(acc_tdata); sel_log.push_back(sel); tl_log.push_back(acc_tlast);
      end
      if (start) begin start_cnt++; grant_log.push_back(grant); end
      if (err_len) err_cnt++;
      if (rs0_tvalid && rs0_tready) rs0_log.push_back(rs0_tdata);
      if (rs1_tvalid) rs1_vcnt++;
      if (rst_n) model_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      acc_tready = acc_toggle ? !acc_tready : 1'b1;
    end
  end

  task automatic clear_logs();
    acc_log.delete(); sel_log.delete(); tl_log.delete(); grant_log.delete(); rs0_log.delete();
    start_cnt = 0; err_cnt = 0; rs1_vcnt = 0;
  endtask

  task automatic drive_rq(input bit idx, input logic v, input logic [31:0] d, input logic l);
    if (idx) begin rq1_tvalid = v; rq1_tdata = d; rq1_tlast = l; end
    else begin rq0_tvalid = v; rq0_tdata = d; rq0_tlast = l; end
  endtask

  // last_at is the 1-based word carrying tlast; 0 means no tlast at all.
  task automatic send_job(input bit idx, input int n, input int last_at, input logic [31:0] base);
    bit acc;
    int g;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      drive_rq(idx, 1'b1, base + 32'(i), (i == last_at - 1));
      acc = 1'b0; g = 0;
      while (!acc) begin
        @(negedge clk);
        acc = idx ? (rq1_tvalid && rq1_tready) : (rq0_tvalid && rq0_tready);
        @(posedge clk); #1;
        g++;
        if (!rst_n) begin drive_rq(idx, 1'b0, '0, 1'b0); return; end
        if (!acc && g > 300) begin fail_timeout("rq_accept"); drive_rq(idx, 1'b0, '0, 1'b0); return; end
      end
    end
    drive_rq(idx, 1'b0, '0, 1'b0);
  endtask

  task automatic send_result(input int n, input logic [31:0] base);
    bit acc;
    int g;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      res_tvalid = 1'b1; res_tdata = base + 32'(i); res_tlast = (i == n - 1);
      acc = 1'b0; g = 0;
      while (!acc) begin
        @(negedge clk);
        acc = res_tvalid && res_tready;
        @(posedge clk); #1;
        g++;
        if (!acc && g > 300) begin fail_timeout("res_accept"); res_tvalid = 1'b0; return; end
      end
    end
    res_tvalid = 1'b0; res_tlast = 1'b0;
  endtask

  task automatic wait_start();
    int g = 0;
    do begin @(negedge clk); g++; end while (!start && g < 300);
    if (!start) fail_timeout("wait_start");
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin @(negedge clk); g++; end while (busy && g < 300);
    if (busy) fail_timeout("wait_idle");
  endtask

  task automatic check_load_log(input string tag, input logic [31:0] base);
    logic [7:0] sel_pat = 8'hF0;
    logic [7:0] tl_pat  = 8'h80;
    check32({tag, "_beats"}, 32'(acc_log.size()), 32'd8);
    for (int i = 0; i < acc_log.size() && i < 8; i++) begin
      check32({tag, "_data"}, acc_log[i], base + 32'(i));
      check1({tag, "_sel"}, sel_log[i], sel_pat[i]);
      check1({tag, "_tlast"}, tl_log[i], tl_pat[i]);
    end
  endtask

  initial begin
    logic [3:0] gpat;
    int g;
    rst_n = 1'b0; acc_toggle = 1'b0; acc_tready = 1'b1;
    rq0_tdata = '0; rq0_tvalid = 1'b0; rq0_tlast = 1'b0;
    rq1_tdata = '0; rq1_tvalid = 1'b0; rq1_tlast = 1'b0;
    res_tdata = '0; res_tvalid = 1'b0; res_tlast = 1'b0;
    rs0_tready = 1'b1; rs1_tready = 1'b1;
    clear_logs();
    repeat (2) @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_grant", grant, 1'b0);
    check1("rst_sel", sel, 1'b0);
    check1("rst_start", start, 1'b0);
    check1("rst_err", err_len, 1'b0);
    check1("rst_acc_tvalid", acc_tvalid, 1'b0);
    check1("rst_res_tready", res_tready, 1'b0);
    check1("rst_rq0_tready", rq0_tready, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Single well-formed job from rq0
    clear_logs();
    fork
      send_job(1'b0, 8, 8, 32'h1);
      begin wait_start(); send_result(4, 32'h100); end
    join
    wait_idle();
    check_load_log("t1", 32'h1);
    check32("t1_starts", 32'(start_cnt), 32'd1);
    check32("t1_errs", 32'(err_cnt), 32'd0);
    check32("t1_rs0_beats", 32'(rs0_log.size()), 32'd4);

    // Alternating grants under contention right after reset
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    fork
      begin send_job(1'b0, 8, 8, 32'h20); send_job(1'b0, 8, 8, 32'h40); end
      begin send_job(1'b1, 8, 8, 32'h30); send_job(1'b1, 8, 8, 32'h50); end
      begin repeat (4) begin wait_start(); send_result(4, 32'h200); end end
    join
    wait_idle();
    gpat = 4'b1010;
    check32("t2_starts", 32'(start_cnt), 32'd4);
    check32("t2_grants", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) check1("t2_grant_order", grant_log[i], gpat[i]);
    check32("t2_beats", 32'(acc_log.size()), 32'd32);
    if (acc_log.size() == 32) begin
      check32("t2_job1_first", acc_log[0], 32'h20);
      check32("t2_job2_first", acc_log[8], 32'h30);
      check32("t2_job3_first", acc_log[16], 32'h40);
      check32("t2_job4_first", acc_log[24], 32'h50);
    end
    check32("t2_rs0_beats", 32'(rs0_log.size()), 32'd8);

    // Accelerator backpressure on alternate cycles
    clear_logs();
    acc_toggle = 1'b1;
    fork
      send_job(1'b0, 8, 8, 32'h11);
      begin wait_start(); send_result(4, 32'h300); end
    join
    wait_idle();
    acc_toggle = 1'b0;
    check_load_log("t3", 32'h11);
    check32("t3_starts", 32'(start_cnt), 32'd1);

    // Early tlast from rq1 on word 5
    clear_logs();
    send_job(1'b1, 5, 5, 32'h60);
    wait_idle();
    repeat (4) @(negedge clk);
    check32("t4_errs", 32'(err_cnt), 32'd1);
    check32("t4_starts", 32'(start_cnt), 32'd0);
    check32("t4_rs1_valid", 32'(rs1_vcnt), 32'd0);
    check32("t4_beats", 32'(acc_log.size()), 32'd5);

    // Missing tlast on the final word still starts the job
    clear_logs();
    fork
      send_job(1'b0, 8, 0, 32'h90);
      begin wait_start(); send_result(4, 32'h310); end
    join
    wait_idle();
    check32("t4b_errs", 32'(err_cnt), 32'd1);
    check32("t4b_starts", 32'(start_cnt), 32'd1);

    // Stalled result consumer
    clear_logs();
    rs0_tready = 1'b0;
    fork
      send_job(1'b0, 8, 8, 32'h70);
      begin wait_start(); repeat (4) @(posedge clk); #1 rs0_tready = 1'b1; end
      begin wait_start(); send_result(4, 32'hA); end
    join
    wait_idle();
    check32("t5_rs0_beats", 32'(rs0_log.size()), 32'd4);
    for (int i = 0; i < rs0_log.size() && i < 4; i++) check32("t5_rs0_data", rs0_log[i], 32'hA + 32'(i));
    check32("t5_rs1_valid", 32'(rs1_vcnt), 32'd0);
    check1("t5_idle", busy, 1'b0);

    // Reset in the middle of a load
    clear_logs();
    fork
      send_job(1'b0, 8, 8, 32'h1);
    join_none
    g = 0;
    while (acc_log.size() < 2 && g < 100) begin @(negedge clk); g++; end
    if (acc_log.size() < 2) fail_timeout("t6_two_words");
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    check1("t6_busy", busy, 1'b0);
    check1("t6_acc_tvalid", acc_tvalid, 1'b0);
    check1("t6_acc_tlast", acc_tlast, 1'b0);
    check1("t6_rq0_tready", rq0_tready, 1'b0);
    check1("t6_sel", sel, 1'b0);
    check1("t6_grant", grant, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    fork
      send_job(1'b0, 8, 8, 32'h1);
      begin wait_start(); send_result(4, 32'h400); end
    join
    wait_idle();
    check_load_log("t6", 32'h1);
    check32("t6_starts", 32'(start_cnt), 32'd1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mm_job_arbiter.md
MM_JOB_ARBITER -- requirements
Module: mm_job_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream word width.
REQ-002 SHALL have parameter DIM_LOG, default 1; SIZE = (2**DIM_LOG)**2 words per matrix; JOB_LEN = 2*SIZE.
REQ-003 SHALL have port s00_axi_aclk  in  1  clock; all logic rising-edge.
REQ-004 SHALL have port s00_axi_aresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports rq0_tdata/rq0_tvalid/rq0_tlast (in, DATA_WIDTH/1/1) and rq0_tready (out, 1), requester-0 job stream slave.
REQ-006 SHALL have ports rq1_tdata/rq1_tvalid/rq1_tlast (in) and rq1_tready (out), requester-1 job stream slave, same widths.
REQ-007 SHALL have ports acc_tdata (out, DATA_WIDTH), acc_tvalid (out, 1), acc_tlast (out, 1), acc_tready (in, 1), stream master to accelerator.
REQ-008 SHALL have ports res_tdata (in, DATA_WIDTH), res_tvalid (in, 1), res_tlast (in, 1), res_tready (out, 1), result stream from accelerator.
REQ-009 SHALL have ports rs0_tdata/rs0_tvalid/rs0_tlast (out) and rs0_tready (in); rs1_* same; result masters per requester.
REQ-010 SHALL have outputs sel (1, matrix select: 0=A, 1=B), start (1, accelerator start pulse), busy (1), grant (1, current owner), err_len (1, length-error pulse).

Function
REQ-011 SHALL implement states IDLE, LOAD, START, WAIT_RES, encoded in a registered state variable.
REQ-012 SHALL hold last_grant register; IDLE arbitration: only one rq*_tvalid high -> grant that requester; both high -> grant = ~last_grant; none -> stay IDLE.
REQ-013 SHALL register grant and last_grant on the IDLE->LOAD edge; no word is transferred in the IDLE cycle.
REQ-014 In LOAD, acc_tdata/acc_tvalid SHALL be combinational copies of the granted rq*_tdata/tvalid; granted rq*_tready = acc_tready; non-granted rq*_tready = 0.
REQ-015 SHALL count accepted words (acc_tvalid & acc_tready) in a counter 0..JOB_LEN-1, cleared on LOAD entry.
REQ-016 sel SHALL be 0 while count < SIZE and 1 while count >= SIZE, valid throughout LOAD.
REQ-017 acc_tlast SHALL be 1 exactly when acc_tvalid and count == JOB_LEN-1, independent of input tlast.
REQ-018 On acceptance of word JOB_LEN-1 with input tlast = 1, SHALL go LOAD->START.
REQ-019 On acceptance of word JOB_LEN-1 with input tlast = 0, SHALL pulse err_len one cycle and go to START; remaining input words are handled as a new job from IDLE.
REQ-020 On acceptance of input tlast = 1 with count < JOB_LEN-1, SHALL pulse err_len one cycle, NOT assert start, go to IDLE.
REQ-021 START SHALL last exactly one cycle with start = 1, then go to WAIT_RES.
REQ-022 In WAIT_RES, granted rs*_tdata/tvalid/tlast SHALL copy res_*; res_tready = granted rs*_tready; non-granted rs*_tvalid = 0.
REQ-023 On accepted result beat with res_tlast = 1, SHALL go to IDLE next cycle; new arbitration allowed in that IDLE cycle.
REQ-024 busy SHALL be 1 in LOAD, START, WAIT_RES; 0 in IDLE.
REQ-025 res_tready SHALL be 0 outside WAIT_RES; rq*_tready SHALL be 0 outside LOAD.
REQ-026 Backpressure: a beat with tvalid=1, tready=0 SHALL hold count, sel and acc_tlast unchanged.

Reset
REQ-027 Reset assertion at any time, including mid-LOAD or mid-WAIT_RES, SHALL force state=IDLE, count=0, last_grant=1, grant=0, start=0, err_len=0, busy=0, sel=0.
REQ-028 During reset all tvalid, tready and tlast outputs SHALL be 0; tdata outputs don't-care.
REQ-029 After reset release, the first contended arbitration SHALL grant requester 0.

Verification
REQ-030 DIM_LOG=1: rq0 sends 8 words 1..8, tlast on 8 -> acc sees 8 beats, sel=0 for 1..4, 1 for 5..8, acc_tlast on 8, one start pulse, err_len=0.
REQ-031 Both requesters valid at cycle after reset -> grant=0 first; after rq0 result tlast, grant=1; third contention -> grant=0.
REQ-032 acc_tready toggled 1/0 each cycle during LOAD -> exactly 8 beats, data order preserved, sel switches after 4th accepted beat.
REQ-033 rq1 tlast on 5th word -> err_len pulse, no start, return IDLE, rs1 receives nothing.
REQ-034 Result 4 beats 0xA..0xD with rs0_tready stalled 3 cycles -> rs0 receives all 4 in order, rs1_tvalid stays 0, IDLE after 0xD.
REQ-035 Reset asserted mid-LOAD (word 3) -> all outputs at reset values immediately; next job restarts count at 0 with sel=0.
